// File: rtl/memory_cycle_pkg.sv
// Shared codes for the memory stage: address/write-data select encodings,
// the RET pop state encoding and the default lowest legal stack address.
package memory_cycle_pkg;

   localparam logic [1:0] ADDR_SEL_DOUT1 = 2'b00;
   localparam logic [1:0] ADDR_SEL_IMM   = 2'b01;
   localparam logic [1:0] ADDR_SEL_SUB   = 2'b10;
   localparam logic [1:0] ADDR_SEL_ALU   = 2'b11;

   localparam logic [2:0] WDATA_SEL_DOUT2 = 3'b000;
   localparam logic [2:0] WDATA_SEL_DOUT1 = 3'b001;
   localparam logic [2:0] WDATA_SEL_PC    = 3'b010;
   localparam logic [2:0] WDATA_SEL_ALU   = 3'b011;
   localparam logic [2:0] WDATA_SEL_FLAGS = 3'b100;

   localparam logic [7:0] STACK_LIMIT_DFLT = 8'h80;

   typedef enum logic {
      RET_IDLE = 1'b0,
      RET_LOAD = 1'b1
   } ret_state_t;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// DEPTH x 8 data memory: synchronous write, synchronous read-first read whose
// registered output holds when not enabled. Array contents are never reset.
module data_memory #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_wen,
   input  logic       i_ren,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [0:DEPTH-1];
   logic [7:0] r_rdata;
   logic       w_in_range;

   assign w_in_range = (32'(i_addr) < DEPTH);

   // Array write; out-of-range addresses are dropped when DEPTH < 256
   always_ff @(posedge clk) begin
      if (i_wen && w_in_range) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read port sees the pre-write contents on a same-address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 8'h00;
      end else if (i_ren) begin
         r_rdata <= w_in_range ? r_mem[i_addr] : 8'h00;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: address/write-data muxing, data memory, RET pop FSM, MEM/WB latch.
// Optional macro STACK_GUARD_EN suppresses stack writes below STACK_LIMIT and flags them.
module memory_cycle
   import memory_cycle_pkg::*;
#(
   parameter int DEPTH = 256
`ifdef STACK_GUARD_EN
   , parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DFLT
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       D_mem_wenM,
   input  logic       D_mem_renM,
   input  logic       sp_mux_sM,
   input  logic       RET_enM,
   input  logic       RET_flushM,
   input  logic [1:0] mux9sM,
   input  logic [2:0] mux10sM,
   input  logic [2:0] mux8sM,
   input  logic [1:0] dest_addrM,
   input  logic [1:0] reg_file_wenM,
   input  logic [3:0] ALU_flagsM,
   input  logic [7:0] ALU_resultM,
   input  logic [7:0] pcM,
   input  logic [7:0] sub_outM,
   input  logic [7:0] instrM,
   input  logic [7:0] Imm_M,
   input  logic [7:0] data_out1M,
   input  logic [7:0] data_out2M,
   output logic [1:0] reg_file_wenWB,
   output logic [1:0] dest_addrWB,
   output logic [2:0] mux8sWB,
   output logic [7:0] ALU_resultWB,
   output logic [7:0] mem_dataWB,
   output logic [7:0] pcWB,
   output logic [7:0] Imm_WB,
   output logic [7:0] sub_outWB,
   output logic [7:0] instrWB,
   output logic [7:0] ret_pc,
   output logic       ret_pc_valid,
   output logic       ret_flush,
   output logic       stack_fault
);

   logic [7:0] w_addr;
   logic [7:0] w_wdata;
   logic [7:0] w_mem_rdata;
   logic       w_wen;
   logic       w_ren;
   logic       w_stack_block;

   ret_state_t r_state;
   ret_state_t w_state_nxt;
   logic [7:0] r_ret_pc_hold;
   logic       r_ret_flush;

   logic [1:0] r_reg_file_wen;
   logic [1:0] r_dest_addr;
   logic [2:0] r_mux8s;
   logic [7:0] r_alu_result;
   logic [7:0] r_pc;
   logic [7:0] r_imm;
   logic [7:0] r_sub_out;
   logic [7:0] r_instr;

   // Address select; stack access overrides the mux9s choice
   always_comb begin
      w_addr = 8'h00;
      if (sp_mux_sM) begin
         w_addr = sub_outM;
      end else begin
         case (mux9sM)
            ADDR_SEL_DOUT1: w_addr = data_out1M;
            ADDR_SEL_IMM:   w_addr = Imm_M;
            ADDR_SEL_SUB:   w_addr = sub_outM;
            ADDR_SEL_ALU:   w_addr = ALU_resultM;
            default:        w_addr = 8'h00;
         endcase
      end
   end

   // Write-data select; flags are zero-extended, unused codes store zero
   always_comb begin
      w_wdata = 8'h00;
      case (mux10sM)
         WDATA_SEL_DOUT2: w_wdata = data_out2M;
         WDATA_SEL_DOUT1: w_wdata = data_out1M;
         WDATA_SEL_PC:    w_wdata = pcM;
         WDATA_SEL_ALU:   w_wdata = ALU_resultM;
         WDATA_SEL_FLAGS: w_wdata = {4'b0000, ALU_flagsM};
         default:         w_wdata = 8'h00;
      endcase
   end

`ifdef STACK_GUARD_EN
   logic r_stack_fault;

   assign w_stack_block = D_mem_wenM & sp_mux_sM & (sub_outM < STACK_LIMIT);

   // Sticky record of any suppressed stack write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stack_fault <= 1'b0;
      end else if (w_stack_block) begin
         r_stack_fault <= 1'b1;
      end
   end

   assign stack_fault = r_stack_fault;
`else
   assign w_stack_block = 1'b0;
   assign stack_fault   = 1'b0;
`endif

   assign w_wen = D_mem_wenM & ~w_stack_block;
   // A RET pop reads the stack slot regardless of the ordinary read enable
   assign w_ren = D_mem_renM | RET_enM;

   data_memory #(
      .DEPTH (DEPTH)
   ) u_data_memory (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wen   (w_wen),
      .i_ren   (w_ren),
      .i_addr  (w_addr),
      .i_wdata (w_wdata),
      .o_rdata (w_mem_rdata)
   );

   // RET FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RET_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // RET FSM next state; LOAD re-enters on a back-to-back RET
   always_comb begin
      w_state_nxt = RET_IDLE;
      case (r_state)
         RET_IDLE: w_state_nxt = RET_enM ? RET_LOAD : RET_IDLE;
         RET_LOAD: w_state_nxt = RET_enM ? RET_LOAD : RET_IDLE;
         default:  w_state_nxt = RET_IDLE;
      endcase
   end

   // Flush qualifier captured on LOAD entry; popped PC kept after LOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ret_flush   <= 1'b0;
         r_ret_pc_hold <= 8'h00;
      end else begin
         r_ret_flush <= RET_enM & RET_flushM;
         if (r_state == RET_LOAD) begin
            r_ret_pc_hold <= w_mem_rdata;
         end else begin
            r_ret_pc_hold <= r_ret_pc_hold;
         end
      end
   end

   assign ret_pc_valid = (r_state == RET_LOAD);
   assign ret_flush    = r_ret_flush;
   assign ret_pc       = (r_state == RET_LOAD) ? w_mem_rdata : r_ret_pc_hold;

   // MEM/WB latch, loaded every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_file_wen <= 2'b00;
         r_dest_addr    <= 2'b00;
         r_mux8s        <= 3'b000;
         r_alu_result   <= 8'h00;
         r_pc           <= 8'h00;
         r_imm          <= 8'h00;
         r_sub_out      <= 8'h00;
         r_instr        <= 8'h00;
      end else begin
         r_reg_file_wen <= reg_file_wenM;
         r_dest_addr    <= dest_addrM;
         r_mux8s        <= mux8sM;
         r_alu_result   <= ALU_resultM;
         r_pc           <= pcM;
         r_imm          <= Imm_M;
         r_sub_out      <= sub_outM;
         r_instr        <= instrM;
      end
   end

   assign reg_file_wenWB = r_reg_file_wen;
   assign dest_addrWB    = r_dest_addr;
   assign mux8sWB        = r_mux8s;
   assign ALU_resultWB   = r_alu_result;
   assign mem_dataWB     = w_mem_rdata;
   assign pcWB           = r_pc;
   assign Imm_WB         = r_imm;
   assign sub_outWB      = r_sub_out;
   assign instrWB        = r_instr;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle; the stack-guard section follows STACK_GUARD_EN.
module tb_memory_cycle;

   logic       clk;
   logic       rst_n;
   logic       D_mem_wenM, D_mem_renM, sp_mux_sM, RET_enM, RET_flushM;
   logic [1:0] mux9sM, dest_addrM, reg_file_wenM;
   logic [2:0] mux10sM, mux8sM;
   logic [3:0] ALU_flagsM;
   logic [7:0] ALU_resultM, pcM, sub_outM, instrM, Imm_M, data_out1M, data_out2M;
   logic [1:0] reg_file_wenWB, dest_addrWB;
   logic [2:0] mux8sWB;
   logic [7:0] ALU_resultWB, mem_dataWB, pcWB, Imm_WB, sub_outWB, instrWB, ret_pc;
   logic       ret_pc_valid, ret_flush, stack_fault;

   int n_total;
   int n_bad;

   memory_cycle dut (
      .clk(clk), .rst_n(rst_n),
      .D_mem_wenM(D_mem_wenM), .D_mem_renM(D_mem_renM), .sp_mux_sM(sp_mux_sM),
      .RET_enM(RET_enM), .RET_flushM(RET_flushM),
      .mux9sM(mux9sM), .mux10sM(mux10sM), .mux8sM(mux8sM),
      .dest_addrM(dest_addrM), .reg_file_wenM(reg_file_wenM), .ALU_flagsM(ALU_flagsM),
      .ALU_resultM(ALU_resultM), .pcM(pcM), .sub_outM(sub_outM), .instrM(instrM),
      .Imm_M(Imm_M), .data_out1M(data_out1M), .data_out2M(data_out2M),
      .reg_file_wenWB(reg_file_wenWB), .dest_addrWB(dest_addrWB), .mux8sWB(mux8sWB),
      .ALU_resultWB(ALU_resultWB), .mem_dataWB(mem_dataWB), .pcWB(pcWB),
      .Imm_WB(Imm_WB), .sub_outWB(sub_outWB), .instrWB(instrWB),
      .ret_pc(ret_pc), .ret_pc_valid(ret_pc_valid), .ret_flush(ret_flush),
      .stack_fault(stack_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total = n_total + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      D_mem_wenM = 1'b0; D_mem_renM = 1'b0; sp_mux_sM = 1'b0;
      RET_enM = 1'b0; RET_flushM = 1'b0;
      mux9sM = 2'b00; mux10sM = 3'b000; mux8sM = 3'b000;
      dest_addrM = 2'b00; reg_file_wenM = 2'b00; ALU_flagsM = 4'h0;
      ALU_resultM = 8'h00; pcM = 8'h00; sub_outM = 8'h00; instrM = 8'h00;
      Imm_M = 8'h00; data_out1M = 8'h00; data_out2M = 8'h00;
   endtask

   // Read mem[imm] through the immediate address path
   task automatic read_imm(input logic [7:0] a);
      idle_inputs();
      mux9sM = 2'b01; Imm_M = a; D_mem_renM = 1'b1;
      step();
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;

      // All inputs nonzero: write C3 to F5, then RET pops it back-to-back
      D_mem_wenM = 1'b1; D_mem_renM = 1'b1; sp_mux_sM = 1'b1;
      RET_enM = 1'b1; RET_flushM = 1'b1;
      mux9sM = 2'b11; mux10sM = 3'b011; mux8sM = 3'b101;
      dest_addrM = 2'b10; reg_file_wenM = 2'b11; ALU_flagsM = 4'hF;
      ALU_resultM = 8'hC3; pcM = 8'h9A; sub_outM = 8'hF5; instrM = 8'h77;
      Imm_M = 8'h3D; data_out1M = 8'h5E; data_out2M = 8'h6F;
      step();
      step();
      check("pre_rst_wen", reg_file_wenWB, 8'h03);
      check("pre_rst_valid", ret_pc_valid, 8'h01);
      check("pre_rst_flush", ret_flush, 8'h01);
      check("pre_rst_ret_pc", ret_pc, 8'hC3);
      check("pre_rst_memdata", mem_dataWB, 8'hC3);

      #3;
      rst_n = 1'b0;
      #1;
      check("rst_reg_file_wenWB", reg_file_wenWB, 8'h00);
      check("rst_dest_addrWB", dest_addrWB, 8'h00);
      check("rst_mux8sWB", mux8sWB, 8'h00);
      check("rst_ALU_resultWB", ALU_resultWB, 8'h00);
      check("rst_mem_dataWB", mem_dataWB, 8'h00);
      check("rst_pcWB", pcWB, 8'h00);
      check("rst_Imm_WB", Imm_WB, 8'h00);
      check("rst_sub_outWB", sub_outWB, 8'h00);
      check("rst_instrWB", instrWB, 8'h00);
      check("rst_ret_pc", ret_pc, 8'h00);
      check("rst_ret_pc_valid", ret_pc_valid, 8'h00);
      check("rst_ret_flush", ret_flush, 8'h00);
      check("rst_stack_fault", stack_fault, 8'h00);
      step();
      idle_inputs();
      rst_n = 1'b1;
      step();
      check("idle_valid", ret_pc_valid, 8'h00);

      // Store A5 at 3C via immediate address, then load it with passthroughs
      mux9sM = 2'b01; Imm_M = 8'h3C; mux10sM = 3'b000; data_out2M = 8'hA5; D_mem_wenM = 1'b1;
      step();
      D_mem_wenM = 1'b0; D_mem_renM = 1'b1;
      pcM = 8'h12; instrM = 8'h5A; dest_addrM = 2'b01; mux8sM = 3'b110;
      reg_file_wenM = 2'b10; ALU_resultM = 8'hE7; sub_outM = 8'h4B;
      step();
      check("load_3C", mem_dataWB, 8'hA5);
      check("wb_pc", pcWB, 8'h12);
      check("wb_instr", instrWB, 8'h5A);
      check("wb_dest", dest_addrWB, 8'h01);
      check("wb_mux8s", mux8sWB, 8'h06);
      check("wb_wen", reg_file_wenWB, 8'h02);
      check("wb_alu", ALU_resultWB, 8'hE7);
      check("wb_sub", sub_outWB, 8'h4B);
      check("wb_imm", Imm_WB, 8'h3C);
      idle_inputs();
      mux9sM = 2'b00; data_out1M = 8'h99;
      step();
      check("memdata_hold", mem_dataWB, 8'hA5);

      // Read-first collision at 10 via ALU-result address
      idle_inputs();
      mux9sM = 2'b11; ALU_resultM = 8'h10; data_out2M = 8'h11; D_mem_wenM = 1'b1;
      step();
      data_out2M = 8'h22; D_mem_renM = 1'b1;
      step();
      check("collide_old", mem_dataWB, 8'h11);
      D_mem_wenM = 1'b0;
      step();
      check("collide_new", mem_dataWB, 8'h22);

      // CALL pushes 47 at FE and 63 at FD
      idle_inputs();
      sp_mux_sM = 1'b1; sub_outM = 8'hFE; mux10sM = 3'b010; pcM = 8'h47; D_mem_wenM = 1'b1;
      mux9sM = 2'b01; Imm_M = 8'h3C;
      step();
      sub_outM = 8'hFD; pcM = 8'h63;
      step();
      idle_inputs();
      sp_mux_sM = 1'b1; sub_outM = 8'hFE; mux9sM = 2'b01; Imm_M = 8'h3C; D_mem_renM = 1'b1;
      step();
      check("sp_override", mem_dataWB, 8'h47);
      idle_inputs();
      step();

      // RET with flush pops 47 for exactly one cycle
      sp_mux_sM = 1'b1; sub_outM = 8'hFE; RET_enM = 1'b1; RET_flushM = 1'b1;
      step();
      check("ret_pc", ret_pc, 8'h47);
      check("ret_valid", ret_pc_valid, 8'h01);
      check("ret_flush", ret_flush, 8'h01);
      idle_inputs();
      step();
      check("ret_valid_drop", ret_pc_valid, 8'h00);
      check("ret_flush_drop", ret_flush, 8'h00);
      check("ret_pc_hold", ret_pc, 8'h47);

      // Back-to-back RET without flush
      sp_mux_sM = 1'b1; sub_outM = 8'hFE; RET_enM = 1'b1; RET_flushM = 1'b0;
      step();
      check("b2b_pc1", ret_pc, 8'h47);
      check("b2b_valid1", ret_pc_valid, 8'h01);
      check("b2b_flush1", ret_flush, 8'h00);
      sub_outM = 8'hFD;
      step();
      check("b2b_pc2", ret_pc, 8'h63);
      check("b2b_valid2", ret_pc_valid, 8'h01);
      idle_inputs();
      step();
      check("b2b_end_valid", ret_pc_valid, 8'h00);
      check("b2b_end_pc", ret_pc, 8'h63);

      // Flags push zero-extends; unused write-data code stores zero
      mux9sM = 2'b01; Imm_M = 8'h20; mux10sM = 3'b100; ALU_flagsM = 4'b1010; D_mem_wenM = 1'b1;
      step();
      read_imm(8'h20);
      check("flags_push", mem_dataWB, 8'h0A);
      idle_inputs();
      mux9sM = 2'b01; Imm_M = 8'h21; mux10sM = 3'b011; ALU_resultM = 8'hFF; D_mem_wenM = 1'b1;
      step();
      mux10sM = 3'b111;
      step();
      read_imm(8'h21);
      check("wdata_other_zero", mem_dataWB, 8'h00);

      // Stack write below the limit
      idle_inputs();
      mux9sM = 2'b01; Imm_M = 8'h7F; data_out2M = 8'h55; D_mem_wenM = 1'b1;
      step();
      idle_inputs();
      sp_mux_sM = 1'b1; sub_outM = 8'h7F; data_out2M = 8'h99; D_mem_wenM = 1'b1;
      step();
      idle_inputs();
      step();
`ifdef STACK_GUARD_EN
      check("guard_fault", stack_fault, 8'h01);
      read_imm(8'h7F);
      check("guard_blocked", mem_dataWB, 8'h55);
      idle_inputs();
      sp_mux_sM = 1'b1; sub_outM = 8'h80; data_out2M = 8'h66; D_mem_wenM = 1'b1;
      step();
      read_imm(8'h80);
      check("guard_limit_ok", mem_dataWB, 8'h66);
      check("guard_sticky", stack_fault, 8'h01);
`else
      check("noguard_fault", stack_fault, 8'h00);
      read_imm(8'h7F);
      check("noguard_write", mem_dataWB, 8'h99);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory stage of the 8-bit pipeline; consumes the EX/MEM latch outputs (ALU result, operands, PC, immediate, stack value, control bits).
- Computes the data-memory address and write data, and owns the 256x8 data memory.
- Sequences RET pops through a small FSM that returns the popped PC to fetch.
- Registers everything the write-back stage needs in a MEM/WB latch.

Parameters:
- DEPTH, 256, data-memory entries; address is 8 bits, so DEPTH must not exceed 256.
- STACK_LIMIT, 8'h80, lowest legal stack write address (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- D_mem_wenM  in  1  data-memory write enable
- D_mem_renM  in  1  data-memory read enable
- sp_mux_sM  in  1  1: force address to sub_outM (stack access)
- RET_enM  in  1  RET in MEM; start pop sequence
- RET_flushM  in  1  flush request accompanying RET
- mux9sM  in  2  address select: 00 data_out1M, 01 Imm_M, 10 sub_outM, 11 ALU_resultM
- mux10sM  in  3  write-data select: 000 data_out2M, 001 data_out1M, 010 pcM, 011 ALU_resultM, 100 {4'b0,ALU_flagsM}, others 8'h00
- mux8sM  in  3  write-back select; passed through
- dest_addrM  in  2  destination register; passed through
- reg_file_wenM  in  2  register-file write enable; passed through
- ALU_flagsM  in  4  {V,C,N,Z} from execute
- ALU_resultM, pcM, sub_outM, instrM, Imm_M, data_out1M, data_out2M  in  8 each  EX/MEM datapath
- reg_file_wenWB, dest_addrWB  out  2 each  latched controls
- mux8sWB  out  3  latched write-back select
- ALU_resultWB, mem_dataWB, pcWB, Imm_WB, sub_outWB, instrWB  out  8 each  MEM/WB latch
- ret_pc  out  8  popped return address
- ret_pc_valid  out  1  one-cycle PC-load strobe to fetch
- ret_flush  out  1  one-cycle flush to IF/ID/EX latches
- stack_fault  out  1  sticky stack-overflow flag (0 when the feature is absent)

Behaviour:
- Reset (rst_n low, asynchronous):
  - All MEM/WB outputs 0, ret_pc 0, ret_pc_valid 0, ret_flush 0, stack_fault 0, FSM in IDLE.
  - Memory contents are not reset.
- Address: addr = sp_mux_sM ? sub_outM : mux9sM-selected source. sp_mux_sM overrides mux9sM.
- Write: on the clk edge with D_mem_wenM=1, mem[addr] <= selected write data.
- Read: synchronous. With D_mem_renM=1, mem_dataWB <= mem[addr] at the same edge that loads the latch (1-cycle latency, aligned with the other WB fields). With D_mem_renM=0, mem_dataWB holds its value.
- Read and write to the same address in the same cycle: read-first; mem_dataWB gets the old data.
- MEM/WB latch: every edge, all WB outputs load their M counterparts. No stall or enable input.
- RET FSM:
  - IDLE: RET_enM=1 forces a read at addr (independent of D_mem_renM) and moves to LOAD.
  - LOAD (exactly one cycle): ret_pc = mem_dataWB, ret_pc_valid = 1, ret_flush = RET_flushM captured at entry. Next state is LOAD again if RET_enM=1 (back-to-back RET accepted), else IDLE.
  - ret_pc holds its value after LOAD.
- RET_enM together with D_mem_wenM=1: the write is performed and the read returns the old data.
- Reset asserted in LOAD: aborts immediately; ret_pc_valid and ret_flush drop asynchronously.
- Widths: all datapath values are 8 bits with no arithmetic in this stage. The flags write zero-extends to 8 bits.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined: a write with sp_mux_sM=1 and sub_outM < STACK_LIMIT is suppressed (memory unchanged) and sets stack_fault. stack_fault stays high until reset. Non-stack writes are never checked.
- Undefined: no check, all writes proceed, stack_fault is tied to 0.

Decomposition:
- Shared package holds:
  - ADDR_SEL_* codes for mux9s.
  - WDATA_SEL_* codes for mux10s.
  - RET FSM state enum {RET_IDLE, RET_LOAD}.
  - STACK_LIMIT default.
- One sub-module, data_memory: DEPTH x 8, synchronous read-first read with read enable, synchronous write with write enable. memory_cycle instantiates it alongside the latch and the FSM.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with all inputs nonzero -> all outputs 0 immediately; reg_file_wenWB=0.
- Store/load via immediate address: mux9sM=01, Imm_M=8'h3C, mux10sM=000, data_out2M=8'hA5, wen=1; next cycle ren=1 with the same address -> mem_dataWB=8'hA5 one edge later.
- Read-first collision: mem[8'h10]=8'h11; same cycle wen=1 and ren=1 at 8'h10 with data 8'h22 -> mem_dataWB=8'h11; a following read -> 8'h22.
- CALL/RET: sp_mux_sM=1, sub_outM=8'hFE, mux10sM=010, pcM=8'h47, wen=1; later RET_enM=1, RET_flushM=1 at sub_outM=8'hFE -> one cycle later ret_pc=8'h47, ret_pc_valid=1, ret_flush=1 for exactly one cycle.
- Flags push: mux10sM=100, ALU_flagsM=4'b1010 -> stored byte 8'h0A.
- STACK_GUARD_EN: stack write at sub_outM=8'h7F -> memory unchanged, stack_fault=1 and sticky; the same write at 8'h80 -> succeeds.
